// File: rtl/jt49_pkg.sv
// Shared constants for the PSG audio back-end: sound width, DC-remover
// output gain and the DC-remover state encoding.
package jt49_pkg;

   localparam int JT49_SNDW         = 10;
   localparam int JT49_DCRM_GAIN_SH = 5;

   typedef logic [0:0] jt49_dcrm_st_t;

   localparam jt49_dcrm_st_t JT49_DCRM_WARM = 1'b0;
   localparam jt49_dcrm_st_t JT49_DCRM_RUN  = 1'b1;

endpackage

// File: rtl/jt49_sat.sv
// Generic signed saturator: narrows an IN_W-bit two's complement value to
// OUT_W bits, clipping symmetrically to +/-(2^(OUT_W-1)-1). When the input is
// narrower than the output it is simply sign-extended.
module jt49_sat #(
   parameter int IN_W  = 17,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  i_din,
   output logic [OUT_W-1:0] o_dout
);

   generate
      if (IN_W >= OUT_W) begin : g_clip
         localparam logic signed [IN_W-1:0] MAXV =
            IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
         localparam logic signed [IN_W-1:0] MINV = -MAXV;

         logic signed [IN_W-1:0] w_in;
         assign w_in = $signed(i_din);

         // clip to the symmetric range, otherwise keep the low bits
         always_comb begin
            o_dout = w_in[OUT_W-1:0];
            if (w_in > MAXV) begin
               o_dout = MAXV[OUT_W-1:0];
            end else if (w_in < MINV) begin
               o_dout = MINV[OUT_W-1:0];
            end else begin
               o_dout = w_in[OUT_W-1:0];
            end
         end
      end else begin : g_ext
         assign o_dout = {{(OUT_W - IN_W){i_din[IN_W-1]}}, i_din};
      end
   endgenerate

endmodule

// File: rtl/jt49_dcrm.sv
// PSG DC remover: box-car decimates the unsigned sound mix by 2^DECIM_LOG2,
// removes the DC bias with a leaky integrator and hands signed samples to the
// consumer through a single-entry valid/ready slot. A warm-up boundary seeds
// the DC estimate so the first sample does not jump.
module jt49_dcrm
   import jt49_pkg::*;
#(
   parameter int DECIM_LOG2 = 3,
   parameter int DCW        = 6,
   parameter int OUTW       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   input  logic [JT49_SNDW-1:0] din,
   input  logic                 enable,
   output logic [OUTW-1:0]      dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 overrun
);

   localparam int ACCW = JT49_SNDW + DECIM_LOG2;  // accumulator never overflows
   localparam int DCVW = JT49_SNDW + DCW;         // DC estimate, DCW fraction bits
   localparam int DIFW = DCVW + 1;                // signed difference
   localparam int SCSH = DCW - JT49_DCRM_GAIN_SH; // gives 32 LSB per input LSB

   // ---------------------------------------------------------------- accumulator
   logic [DECIM_LOG2-1:0] r_cnt;
   logic [ACCW-1:0]       r_acc;
   logic [JT49_SNDW-1:0]  r_mean;
   logic                  r_bnd;    // one-cycle pulse after a boundary edge
   logic                  w_step;
   logic                  w_wrap;
   logic [ACCW-1:0]       w_acc_add;

   assign w_step    = cen & enable;
   assign w_wrap    = w_step & (r_cnt == {DECIM_LOG2{1'b1}});
   assign w_acc_add = r_acc + {{DECIM_LOG2{1'b0}}, din};

   // sum din over each group of 2^DECIM_LOG2 strobes and latch the mean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_mean <= '0;
         r_bnd  <= 1'b0;
      end else if (!enable) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_bnd  <= 1'b0;
      end else begin
         r_bnd <= w_wrap;
         if (w_step) begin
            r_cnt <= r_cnt + DECIM_LOG2'(1);
            if (w_wrap) begin
               r_mean <= w_acc_add[ACCW-1:DECIM_LOG2];
               r_acc  <= '0;
            end else begin
               r_acc  <= w_acc_add;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   jt49_dcrm_st_t r_state;
   jt49_dcrm_st_t w_state_nx;
   logic          w_seed;   // warm-up boundary: load the DC estimate directly
   logic          w_filt;   // running boundary: filter and offer a sample

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= JT49_DCRM_WARM;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // next state: leave warm-up on the first boundary, any disable restarts it
   always_comb begin
      w_state_nx = r_state;
      if (!enable) begin
         w_state_nx = JT49_DCRM_WARM;
      end else if (r_bnd) begin
         case (r_state)
            JT49_DCRM_WARM: w_state_nx = JT49_DCRM_RUN;
            JT49_DCRM_RUN:  w_state_nx = JT49_DCRM_RUN;
            default:        w_state_nx = JT49_DCRM_WARM;
         endcase
      end else begin
         w_state_nx = r_state;
      end
   end

   // state outputs: what the filter stage does on a boundary
   always_comb begin
      w_seed = 1'b0;
      w_filt = 1'b0;
      if (enable & r_bnd) begin
         case (r_state)
            JT49_DCRM_WARM: w_seed = 1'b1;
            JT49_DCRM_RUN:  w_filt = 1'b1;
            default: begin
               w_seed = 1'b0;
               w_filt = 1'b0;
            end
         endcase
      end else begin
         w_seed = 1'b0;
         w_filt = 1'b0;
      end
   end

   // ---------------------------------------------------------------- DC filter
   logic        [DCVW-1:0] r_dc;
   logic signed [DIFW-1:0] r_diff;
   logic                   r_offer;
   logic        [DCVW-1:0] w_mean_sh;
   logic signed [DIFW-1:0] w_diff;
   logic        [DCVW-1:0] w_dc_next;

   assign w_mean_sh = {r_mean, {DCW{1'b0}}};
   assign w_diff    = $signed({1'b0, w_mean_sh}) - $signed({1'b0, r_dc});
   // the leak never pushes dc past the mean, so the sum stays in DCVW bits
   assign w_dc_next = r_dc + DCVW'(w_diff >>> DCW);

   // seed or update the DC estimate and register the pre-update difference
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dc    <= '0;
         r_diff  <= '0;
         r_offer <= 1'b0;
      end else if (!enable) begin
         r_dc    <= '0;
         r_offer <= 1'b0;
      end else begin
         r_offer <= w_filt;
         if (w_seed) begin
            r_dc <= w_mean_sh;
         end else if (w_filt) begin
            r_dc   <= w_dc_next;
            r_diff <= w_diff;
         end
      end
   end

   // ---------------------------------------------------------------- output slot
   logic signed [DIFW-1:0] w_scaled;
   logic        [OUTW-1:0] w_sat;
   logic        [OUTW-1:0] r_dout;
   logic                   r_dout_valid;
   logic                   r_overrun;
   logic                   w_accept;

   assign w_scaled = r_diff >>> SCSH;
   assign w_accept = r_dout_valid & dout_ready;

   jt49_sat #(
      .IN_W  (DIFW),
      .OUT_W (OUTW)
   ) u_sat (
      .i_din  (w_scaled),
      .o_dout (w_sat)
   );

   // single holding register: load when free or freed this cycle, else drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (!enable) begin
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (r_offer) begin
         if (!r_dout_valid || dout_ready) begin
            r_dout       <= w_sat;
            r_dout_valid <= 1'b1;
         end else begin
            r_overrun    <= 1'b1;
         end
      end else if (w_accept) begin
         r_dout_valid <= 1'b0;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_jt49_dcrm.sv
// Directed bench for jt49_dcrm: default build (DCW=6, OUTW=16) for warm-up,
// step response, handshake, flush and reset; a DCW=5/OUTW=12 build for
// output saturation at the maximum input rate.
module tb_jt49_dcrm;

   logic        clk;
   logic        rst_n;
   logic        cen;
   logic [9:0]  din;
   logic        enable;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        overrun;

   logic        b_cen;
   logic [9:0]  b_din;
   logic        b_enable;
   logic [11:0] b_dout;
   logic        b_valid;
   logic        b_ready;
   logic        b_overrun;

   int n_pass  = 0;
   int n_total = 0;
   int g_outs;
   int g_last;
   int first;
   int fval;
   int nout;
   int nz;

   jt49_dcrm #(.DECIM_LOG2(3), .DCW(6), .OUTW(16)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cen        (cen),
      .din        (din),
      .enable     (enable),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun)
   );

   jt49_dcrm #(.DECIM_LOG2(3), .DCW(5), .OUTW(12)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .cen        (b_cen),
      .din        (b_din),
      .enable     (b_enable),
      .dout       (b_dout),
      .dout_valid (b_valid),
      .dout_ready (b_ready),
      .overrun    (b_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // one cen strobe followed by three idle clocks; optionally raise
   // dout_ready just before clock rdy_k of this window
   task automatic cen4(input int rdy_k);
      for (int k = 0; k < 4; k++) begin
         cen = (k == 0);
         if (k == rdy_k) dout_ready = 1'b1;
         @(posedge clk);
         #1;
         if (dout_valid) begin
            g_outs++;
            g_last = int'($signed(dout));
         end
      end
      cen = 1'b0;
   endtask

   // eight strobes = one decimation boundary at the last strobe
   task automatic group8(input int rdy_k);
      g_outs = 0;
      g_last = -99999;
      for (int j = 0; j < 7; j++) cen4(-1);
      cen4(rdy_k);
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b0; din = 10'd0; enable = 1'b0; dout_ready = 1'b0;
      b_cen = 1'b0; b_din = 10'd0; b_enable = 1'b0; b_ready = 1'b0;
      #12;
      chk("rst_dout", int'($signed(dout)), 0);
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_ovr", int'(overrun), 0);
      chk("rst_b_dout", int'($signed(b_dout)), 0);
      chk("rst_b_valid", int'(b_valid), 0);

      @(posedge clk); #1;
      rst_n = 1'b1; enable = 1'b1; dout_ready = 1'b1; din = 10'd512;

      // constant input: warm-up gives nothing, afterwards zeros
      group8(-1); chk("warm_none", g_outs, 0);
      group8(-1); chk("const_cnt", g_outs, 1); chk("const_val", g_last, 0);
      group8(-1); chk("const_val2", g_last, 0);

      // step 512 -> 640
      din = 10'd640;
      group8(-1); chk("step1", g_last, 4096);
      group8(-1); chk("step2", g_last, 4032);
      group8(-1); chk("step3", g_last, 3969);

      // held sample, then accept exactly on the load edge of the next one
      dout_ready = 1'b0;
      group8(-1); chk("hold_val", g_last, 3907); chk("hold_valid", int'(dout_valid), 1);
      group8(2);
      chk("simul_val", g_last, 3846);
      chk("simul_ovr", int'(overrun), 0);
      chk("simul_drained", int'(dout_valid), 0);

      // backpressure across two boundaries
      dout_ready = 1'b0;
      group8(-1); chk("bp_hold", g_last, 3786); chk("bp_valid", int'(dout_valid), 1);
      chk("bp_ovr0", int'(overrun), 0);
      group8(-1); chk("bp_keep", g_last, 3786); chk("bp_dout", int'($signed(dout)), 3786);
      chk("bp_ovr1", int'(overrun), 1);
      dout_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_acc_valid", int'(dout_valid), 0);
      chk("bp_acc_ovr", int'(overrun), 1);

      // flush with a pending sample, mid-accumulation
      dout_ready = 1'b0;
      group8(-1); chk("fl_pend", g_last, 3669);
      for (int j = 0; j < 5; j++) cen4(-1);
      enable = 1'b0;
      @(posedge clk); #1;
      chk("fl_valid", int'(dout_valid), 0);
      chk("fl_ovr", int'(overrun), 0);
      enable = 1'b1; dout_ready = 1'b1;
      group8(-1); chk("rewarm_none", g_outs, 0);
      group8(-1); chk("rewarm_cnt", g_outs, 1); chk("rewarm_val", g_last, 0);

      // maximum rate: cen every clock, step 640 -> 1023
      dout_ready = 1'b0; din = 10'd1023; cen = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      chk("max_valid", int'(dout_valid), 1);
      chk("max_val", int'($signed(dout)), 12256);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dout", int'($signed(dout)), 0);
      chk("arst_valid", int'(dout_valid), 0);
      chk("arst_ovr", int'(overrun), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; dout_ready = 1'b1;
      first = -1; fval = -99999; nout = 0; nz = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (dout_valid) begin
            nout++;
            if (dout != 16'd0) nz++;
            if (first < 0) begin
               first = i;
               fval = int'($signed(dout));
            end
         end
      end
      chk("rr_first", first, 18);
      chk("rr_val", fval, 0);
      chk("rr_count", nout, 3);
      chk("rr_nonzero", nz, 0);
      cen = 1'b0;

      // narrow build: step 0 -> 1023 saturates to 2047
      b_enable = 1'b1; b_ready = 1'b1; b_din = 10'd0; b_cen = 1'b1;
      first = -1; fval = -99999;
      for (int i = 1; i <= 24; i++) begin
         if (i == 9) b_din = 10'd1023;
         @(posedge clk); #1;
         if (b_valid && first < 0) begin
            first = i;
            fval = int'($signed(b_dout));
         end
      end
      chk("b_first", first, 18);
      chk("b_sat", fval, 2047);
      chk("b_ovr", int'(b_overrun), 0);
      b_cen = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
